// File: rtl/interlock_pkg.sv
// Shared constants for the interlock read-response slice: register pages,
// page-3 indices, read FSM encoding and the coefficient word extractor.
package interlock_pkg;

    localparam logic [10:0] COEFF_PAGE  = 11'd2;
    localparam logic [10:0] STAT_PAGE   = 11'd3;

    localparam logic [4:0]  IDX_STATUS  = 5'd0;
    localparam logic [4:0]  IDX_TRIP_TS = 5'd1;
    localparam logic [4:0]  IDX_NOW     = 5'd2;
    localparam logic [4:0]  IDX_CNT     = 5'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESP   = 2'd2
    } rd_state_t;

    function automatic logic [31:0] coeff_word(input logic [143:0] bus, input logic [2:0] k);
        return {14'd0, bus[int'(k) * 18 +: 18]};
    endfunction

endpackage

// File: rtl/interlock_trip_latch.sv
// Rising-edge trip detector with sticky flag, first-trip timestamp and a
// saturating trip counter; a trip coinciding with clear wins over the clear.
module interlock_trip_latch
    import interlock_pkg::*;
#(
    parameter int TRIP_CNT_W = 16
)(
    input  logic                  trn_clk,
    input  logic                  pio_reset,
    input  logic                  rtn_out,
    input  logic                  clear,
    input  logic [31:0]           timestamp,
    output logic                  trip_sticky,
    output logic [31:0]           trip_ts,
    output logic [TRIP_CNT_W-1:0] trip_cnt
);

    logic rtn_prev;
    logic trip;

    assign trip = rtn_out & ~rtn_prev;

    always_ff @(posedge trn_clk) begin
        if (pio_reset) begin
            rtn_prev    <= 1'b0;
            trip_sticky <= 1'b0;
            trip_ts     <= '0;
            trip_cnt    <= '0;
        end else begin
            rtn_prev <= rtn_out;
            if (trip) begin
                trip_sticky <= 1'b1;
                // A clear in the same cycle restarts the count at this trip.
                if (clear)
                    trip_cnt <= TRIP_CNT_W'(1);
                else if (trip_cnt != {TRIP_CNT_W{1'b1}})
                    trip_cnt <= trip_cnt + TRIP_CNT_W'(1);
                if (!trip_sticky || clear)
                    trip_ts <= timestamp;
            end else if (clear) begin
                trip_sticky <= 1'b0;
                trip_cnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/interlock_rd_resp.sv
// Interlock register read responder: IDLE/DECODE/RESP handshake FSM over the
// status page and, with INTERLOCK_COEFF_RDBK_EN defined, coefficient readback.
module interlock_rd_resp
    import interlock_pkg::*;
#(
    parameter int          TRIP_CNT_W   = 16,
    parameter logic [31:0] UNMAPPED_VAL = 32'hFFFF_FFFF
)(
    input  logic         trn_clk,
    input  logic         pio_reset,
    input  logic [15:0]  reg_offset,
    input  logic         reg_rd_req,
    input  logic         reg_rd_ready,
    output logic [31:0]  reg_rd_data,
    output logic         reg_rd_valid,
    output logic         reg_rd_busy,
    input  logic [143:0] coeff_bus,
    input  logic         rtn_out,
    input  logic         stream_on
);

    rd_state_t             state, state_nxt;
    logic [15:0]           offset_q;
    logic                  clr_on_accept;
    logic [31:0]           ts_q;
    logic [31:0]           rd_mux;
    logic                  accept;
    logic                  trip_clear;
    logic                  trip_sticky;
    logic [31:0]           trip_ts;
    logic [TRIP_CNT_W-1:0] trip_cnt;
    logic [10:0]           page;
    logic [4:0]            idx;

    assign page        = offset_q[15:5];
    assign idx         = offset_q[4:0];
    assign accept      = reg_rd_valid & reg_rd_ready;
    assign trip_clear  = accept & clr_on_accept;
    assign reg_rd_busy = (state != IDLE);

    always_ff @(posedge trn_clk) begin
        if (pio_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (reg_rd_req) state_nxt = DECODE;
            DECODE:  state_nxt = RESP;
            RESP:    if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = UNMAPPED_VAL;
        if (page == STAT_PAGE) begin
            case (idx)
                IDX_STATUS:  rd_mux = {trip_sticky, stream_on, rtn_out, 5'b0, 24'(trip_cnt)};
                IDX_TRIP_TS: rd_mux = trip_ts;
                IDX_NOW:     rd_mux = ts_q;
                IDX_CNT:     rd_mux = 32'(trip_cnt);
                default:     rd_mux = UNMAPPED_VAL;
            endcase
        end
`ifdef INTERLOCK_COEFF_RDBK_EN
        else if (page == COEFF_PAGE && offset_q[4:3] == 2'b00) begin
            rd_mux = coeff_word(coeff_bus, offset_q[2:0]);
        end
`endif
    end

`ifndef INTERLOCK_COEFF_RDBK_EN
    logic unused_coeff;
    assign unused_coeff = ^coeff_bus;
`endif

    // Response data is a snapshot taken in DECODE; valid follows one cycle later.
    always_ff @(posedge trn_clk) begin
        if (pio_reset) begin
            offset_q      <= '0;
            clr_on_accept <= 1'b0;
            reg_rd_data   <= '0;
            reg_rd_valid  <= 1'b0;
            ts_q          <= '0;
        end else begin
            ts_q <= stream_on ? ts_q + 32'd1 : 32'd0;
            if (state == IDLE && reg_rd_req)
                offset_q <= reg_offset;
            if (state == DECODE) begin
                reg_rd_data   <= rd_mux;
                clr_on_accept <= (page == STAT_PAGE) && (idx == IDX_STATUS);
            end
            if (accept)
                reg_rd_valid <= 1'b0;
            else if (state == RESP)
                reg_rd_valid <= 1'b1;
        end
    end

    interlock_trip_latch #(
        .TRIP_CNT_W (TRIP_CNT_W)
    ) u_trip_latch (
        .trn_clk     (trn_clk),
        .pio_reset   (pio_reset),
        .rtn_out     (rtn_out),
        .clear       (trip_clear),
        .timestamp   (ts_q),
        .trip_sticky (trip_sticky),
        .trip_ts     (trip_ts),
        .trip_cnt    (trip_cnt)
    );

endmodule

// File: tb/tb_interlock_rd_resp.sv
// Directed bench for interlock_rd_resp: a default instance and a TRIP_CNT_W=4
// instance share stimulus; coefficient expectations follow INTERLOCK_COEFF_RDBK_EN.
module tb_interlock_rd_resp;

`ifdef INTERLOCK_COEFF_RDBK_EN
    localparam bit COEFF_EN = 1'b1;
`else
    localparam bit COEFF_EN = 1'b0;
`endif

    logic         trn_clk = 1'b0;
    logic         pio_reset;
    logic [15:0]  reg_offset;
    logic         reg_rd_req;
    logic         reg_rd_ready;
    logic [143:0] coeff_bus;
    logic         rtn_out;
    logic         stream_on;
    logic [31:0]  reg_rd_data, reg_rd_data4;
    logic         reg_rd_valid, reg_rd_valid4;
    logic         reg_rd_busy, reg_rd_busy4;

    int           vectors = 0;
    int           miscompares = 0;
    logic [31:0]  ts_model;
    logic [31:0]  rdata, rdata4, now_dec, trip_ts_exp;

    always #5 trn_clk = ~trn_clk;

    interlock_rd_resp dut (
        .trn_clk      (trn_clk),
        .pio_reset    (pio_reset),
        .reg_offset   (reg_offset),
        .reg_rd_req   (reg_rd_req),
        .reg_rd_ready (reg_rd_ready),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .reg_rd_busy  (reg_rd_busy),
        .coeff_bus    (coeff_bus),
        .rtn_out      (rtn_out),
        .stream_on    (stream_on)
    );

    interlock_rd_resp #(.TRIP_CNT_W(4)) dut4 (
        .trn_clk      (trn_clk),
        .pio_reset    (pio_reset),
        .reg_offset   (reg_offset),
        .reg_rd_req   (reg_rd_req),
        .reg_rd_ready (reg_rd_ready),
        .reg_rd_data  (reg_rd_data4),
        .reg_rd_valid (reg_rd_valid4),
        .reg_rd_busy  (reg_rd_busy4),
        .coeff_bus    (coeff_bus),
        .rtn_out      (rtn_out),
        .stream_on    (stream_on)
    );

    task automatic tick();
        @(posedge trn_clk);
        if (pio_reset || !stream_on)
            ts_model = 32'd0;
        else
            ts_model = ts_model + 32'd1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] off);
        int n;
        reg_offset   = off;
        reg_rd_req   = 1'b1;
        reg_rd_ready = 1'b1;
        tick();
        reg_rd_req = 1'b0;
        now_dec    = ts_model;
        n = 0;
        while (!reg_rd_valid && n < 8) begin
            tick();
            n++;
        end
        chk($sformatf("rd_valid_%h", off), {31'b0, reg_rd_valid}, 32'd1);
        rdata  = reg_rd_data;
        rdata4 = reg_rd_data4;
        tick();
    endtask

    initial begin
        pio_reset    = 1'b1;
        reg_offset   = 16'h0000;
        reg_rd_req   = 1'b0;
        reg_rd_ready = 1'b0;
        rtn_out      = 1'b0;
        stream_on    = 1'b0;
        ts_model     = 32'd0;
        coeff_bus    = '0;
        coeff_bus[0 +: 18]      = 18'h1_2345;
        coeff_bus[18*5 +: 18]   = 18'h2_ABCD;
        coeff_bus[18*7 +: 18]   = 18'h3_FFFF;
        tick();
        tick();
        chk("rst_valid", {31'b0, reg_rd_valid}, 32'd0);
        chk("rst_busy", {31'b0, reg_rd_busy}, 32'd0);
        chk("rst_data", reg_rd_data, 32'd0);
        pio_reset = 1'b0;
        tick();

        // Coefficient readback latency and busy profile
        reg_offset   = 16'h0045;
        reg_rd_req   = 1'b1;
        reg_rd_ready = 1'b1;
        tick();
        reg_rd_req = 1'b0;
        chk("lat1_busy", {31'b0, reg_rd_busy}, 32'd1);
        chk("lat1_valid", {31'b0, reg_rd_valid}, 32'd0);
        tick();
        chk("lat2_busy", {31'b0, reg_rd_busy}, 32'd1);
        chk("lat2_valid", {31'b0, reg_rd_valid}, 32'd0);
        tick();
        chk("lat3_busy", {31'b0, reg_rd_busy}, 32'd1);
        chk("lat3_valid", {31'b0, reg_rd_valid}, 32'd1);
        chk("coeff5", reg_rd_data, COEFF_EN ? 32'h0002_ABCD : 32'hFFFF_FFFF);
        tick();
        chk("lat4_busy", {31'b0, reg_rd_busy}, 32'd0);
        chk("lat4_valid", {31'b0, reg_rd_valid}, 32'd0);

        rd(16'h0040); chk("coeff0", rdata, COEFF_EN ? 32'h0001_2345 : 32'hFFFF_FFFF);
        rd(16'h0047); chk("coeff7", rdata, COEFF_EN ? 32'h0003_FFFF : 32'hFFFF_FFFF);
        rd(16'h0048); chk("coeff_hole", rdata, 32'hFFFF_FFFF);
        rd(16'h0100); chk("unmapped_page", rdata, 32'hFFFF_FFFF);
        rd(16'h0064); chk("stat_idx4", rdata, 32'hFFFF_FFFF);

        // First-trip timestamp: stream starts, trip at cycle 100, second at 200
        stream_on = 1'b1;
        repeat (100) tick();
        rtn_out = 1'b1;
        tick();
        rd(16'h0061); chk("trip_ts_first", rdata, 32'd100);
        rd(16'h0062); chk("now_ts", rdata, now_dec);
        rtn_out = 1'b0;
        tick();
        while (ts_model < 32'd200) tick();
        rtn_out = 1'b1;
        tick();
        rd(16'h0061); chk("trip_ts_kept", rdata, 32'd100);
        rd(16'h0063); chk("trip_cnt2", rdata, 32'd2);

        // Status read held by ready low; stray request must be ignored
        reg_offset   = 16'h0060;
        reg_rd_req   = 1'b1;
        reg_rd_ready = 1'b0;
        tick();
        reg_rd_req = 1'b0;
        tick();
        tick();
        chk("hold_valid0", {31'b0, reg_rd_valid}, 32'd1);
        chk("hold_data0", reg_rd_data, 32'hE000_0002);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                reg_offset = 16'h0061;
                reg_rd_req = 1'b1;
            end else begin
                reg_rd_req = 1'b0;
            end
            tick();
            chk($sformatf("hold_valid%0d", i + 1), {31'b0, reg_rd_valid}, 32'd1);
            chk($sformatf("hold_data%0d", i + 1), reg_rd_data, 32'hE000_0002);
        end
        reg_rd_req   = 1'b0;
        reg_rd_ready = 1'b1;
        tick();
        reg_rd_ready = 1'b0;
        chk("post_accept_busy", {31'b0, reg_rd_busy}, 32'd0);
        tick();
        chk("no_queue_busy", {31'b0, reg_rd_busy}, 32'd0);
        chk("no_queue_valid", {31'b0, reg_rd_valid}, 32'd0);
        rd(16'h0060); chk("status_cleared", rdata, 32'h6000_0000);

        // Trip in the same cycle as the clearing acceptance
        rtn_out = 1'b0;
        tick();
        reg_offset   = 16'h0060;
        reg_rd_req   = 1'b1;
        reg_rd_ready = 1'b0;
        tick();
        reg_rd_req = 1'b0;
        tick();
        tick();
        chk("coinc_valid", {31'b0, reg_rd_valid}, 32'd1);
        rtn_out      = 1'b1;
        reg_rd_ready = 1'b1;
        trip_ts_exp  = ts_model;
        tick();
        reg_rd_ready = 1'b0;
        rd(16'h0060); chk("coinc_status", rdata, 32'hE000_0001);
        rd(16'h0061); chk("coinc_trip_ts", rdata, trip_ts_exp);

        // Reset while a read sits in DECODE
        reg_offset   = 16'h0061;
        reg_rd_req   = 1'b1;
        reg_rd_ready = 1'b1;
        tick();
        reg_rd_req = 1'b0;
        pio_reset  = 1'b1;
        stream_on  = 1'b0;
        rtn_out    = 1'b0;
        tick();
        pio_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_valid%0d", i), {31'b0, reg_rd_valid}, 32'd0);
            chk($sformatf("abort_busy%0d", i), {31'b0, reg_rd_busy}, 32'd0);
        end
        chk("abort_data", reg_rd_data, 32'd0);
        rd(16'h0061); chk("rst_trip_ts", rdata, 32'd0);
        rd(16'h0062); chk("rst_now", rdata, 32'd0);
        rd(16'h0063); chk("rst_cnt", rdata, 32'd0);
        rd(16'h0060); chk("rst_status", rdata, 32'h0000_0000);
        rd(16'h0045); chk("post_rst_coeff5", rdata, COEFF_EN ? 32'h0002_ABCD : 32'hFFFF_FFFF);

        // Saturation of a 4-bit trip counter
        for (int i = 0; i < 20; i++) begin
            rtn_out = 1'b1;
            tick();
            rtn_out = 1'b0;
            tick();
        end
        rd(16'h0063);
        chk("cnt20_w16", rdata, 32'd20);
        chk("cnt20_w4", rdata4, 32'd15);
        rd(16'h0060);
        chk("status_w16", rdata, 32'h8000_0014);
        chk("status_w4", rdata4, 32'h8000_000F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interlock_rd_resp.md
INTERLOCK_RD_RESP -- requirements
Module: interlock_rd_resp

Interface
REQ-001 SHALL have parameter TRIP_CNT_W, default 16: trip counter width, 1..24.
REQ-002 SHALL have parameter UNMAPPED_VAL, default 32'hFFFF_FFFF: read data returned for unmapped offsets.
REQ-003 SHALL have port trn_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port pio_reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port reg_offset, input, 16: read address, sampled with reg_rd_req.
REQ-006 SHALL have port reg_rd_req, input, 1: one-cycle read request strobe.
REQ-007 SHALL have port reg_rd_ready, input, 1: host accepts reg_rd_data.
REQ-008 SHALL have port reg_rd_data, output, 32: read response data.
REQ-009 SHALL have port reg_rd_valid, output, 1: reg_rd_data is valid.
REQ-010 SHALL have port reg_rd_busy, output, 1: high whenever the FSM is not IDLE.
REQ-011 SHALL have port coeff_bus, input, 144: eight 18-bit coefficients; coefficient k occupies bits [18k+17:18k].
REQ-012 SHALL have port rtn_out, input, 1: interlock trip level from the calculation block.
REQ-013 SHALL have port stream_on, input, 1: acquisition-active level.

Function
REQ-014 SHALL implement FSM states IDLE, DECODE and RESP; IDLE->DECODE on reg_rd_req; DECODE->RESP always; RESP->IDLE when reg_rd_valid and reg_rd_ready are both high.
REQ-015 SHALL ignore reg_rd_req outside IDLE: no queueing, no side effects.
REQ-016 SHALL raise reg_rd_valid two cycles after the accepted reg_rd_req and hold reg_rd_valid and reg_rd_data stable until acceptance.
REQ-017 SHALL implement page 2 (reg_offset[15:5]==2): data = zero-extended coeff_bus word reg_offset[2:0]; reg_offset[4:3]!=0 returns UNMAPPED_VAL.
REQ-018 SHALL implement page 3 (reg_offset[15:5]==3) idx 0: status = {trip_sticky, stream_on, rtn_out, 5'b0, zero-extended trip_cnt in bits [23:0]}.
REQ-019 SHALL return, on page 3 idx 1, trip_ts (the timestamp of the first trip since the last clear).
REQ-020 SHALL return, on page 3 idx 2, the live timestamp; on page 3 idx 3, trip_cnt; on any other idx or page, UNMAPPED_VAL.
REQ-021 SHALL capture page-3 data at the DECODE cycle; it is a snapshot and is not updated while in RESP.
REQ-022 SHALL run a 32-bit timestamp that increments every cycle while stream_on=1, is held at 0 while stream_on=0, and wraps from 0xFFFF_FFFF to 0.
REQ-023 SHALL detect a trip as a rtn_out 0->1 transition against a registered previous value.
REQ-024 SHALL, on each trip, increment trip_cnt, saturating at all-ones.
REQ-025 SHALL, on a trip while trip_sticky=0, set trip_sticky and load trip_ts with the current timestamp.
REQ-026 SHALL clear trip_sticky and trip_cnt on acceptance of a page 3 idx 0 read (clear-on-read).
REQ-027 SHALL give a trip in the same cycle as that acceptance priority: sticky=1, trip_cnt=1, and trip_ts reloaded.
REQ-028 SHALL not clear trip_ts on read.

Reset
REQ-029 SHALL, with pio_reset=1, set the FSM to IDLE; reg_rd_valid=0, reg_rd_busy=0, reg_rd_data=0; timestamp, trip_ts and trip_cnt=0; trip_sticky=0; registered previous rtn_out=0.
REQ-030 SHALL abort any read in flight on reset and produce no response.

Configuration
REQ-031 SHALL, with INTERLOCK_COEFF_RDBK_EN defined, implement page 2 per REQ-017.
REQ-032 SHALL, without INTERLOCK_COEFF_RDBK_EN, return UNMAPPED_VAL for all of page 2, leave coeff_bus unused, and keep the latency unchanged.

Structure
REQ-033 SHALL place page constants (COEFF_PAGE=11'd2, STAT_PAGE=11'd3), status/ts/now/cnt index constants and the FSM state encoding in shared package interlock_pkg.
REQ-034 SHALL put the edge detect, sticky flag, trip_ts and trip_cnt in sub-module interlock_trip_latch; that sub-module has inputs for clear and timestamp.

Verification
REQ-035 SHALL check: macro on, coeff_bus word 5 = 18'h2_ABCD, read 0x0045 with ready held high -> valid at request+2 with 32'h0002_ABCD, busy for 3 cycles.
REQ-036 SHALL check: stream_on rises at cycle 0, rtn_out rises at cycle 100, read 0x0061 -> 32'd100; a second trip at 200 leaves the value at 100 and trip_cnt=2.
REQ-037 SHALL check: read 0x0060 with ready held low for 5 cycles -> data stable, a second reg_rd_req ignored; after acceptance sticky=0 and cnt=0; a trip in the acceptance cycle -> sticky=1 and cnt=1.
REQ-038 SHALL check: TRIP_CNT_W=4, 20 trips -> cnt reads 15.
REQ-039 SHALL check: macro off, read 0x0040 -> 32'hFFFF_FFFF; read 0x0100 -> 32'hFFFF_FFFF.
REQ-040 SHALL check: pio_reset asserted in DECODE -> no valid afterwards, all counters 0; the next read works normally.
